// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Initiator-side master for a single-ported, word-only data memory. Accepts
// RISC-V style load/store requests (funct3 width encoding), performs byte and
// halfword loads by extract plus sign/zero extension, and sub-word stores by a
// read-modify-write sequence on the containing word. One request outstanding.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_store       1 = store, 0 = load
//   req_funct3      000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid/ready response handshake
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         misaligned access or illegal funct3
//   mem_A           word address to memory
//   mem_WD          write data to memory
//   mem_MemWrite    memory write enable
//   mem_RD          combinational memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned ADDR_W          = 32,
   parameter bit          ERR_ON_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_A,
   output logic [31:0]       mem_WD,
   output logic              mem_MemWrite,
   input  logic [31:0]       mem_RD
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_funct3;
   logic                r_store;
   // Holds the raw store data after accept; overwritten by the merged word
   // in READ for sub-word stores, so it is always what WRITE should drive.
   logic [31:0]         r_mem_wd;
   logic [31:0]         r_rdata;
   logic                r_err;

   logic                w_accept;
   logic                w_illegal;
   logic                w_misalign;
   logic                w_err_req;
   logic [ADDR_W-1:0]   w_addr_aligned;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load_data;
   logic [31:0]         w_merged;

   assign w_accept = req_valid && (r_state == StIdle);

   // Request decode
   assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_store && req_funct3[2]);
   assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_err_req  = w_illegal || (ERR_ON_MISALIGN && w_misalign);

   // Forcing alignment is harmless when misalignment is reported as an error,
   // since that path never touches memory.
   always_comb begin
      w_addr_aligned = req_addr;
      case (req_funct3[1:0])
         2'b01:   w_addr_aligned = {req_addr[ADDR_W-1:1], 1'b0};
         2'b10:   w_addr_aligned = {req_addr[ADDR_W-1:2], 2'b00};
         default: w_addr_aligned = req_addr;
      endcase
   end

   // Lane extract (little-endian)
   always_comb begin
      w_byte = mem_RD[7:0];
      case (r_addr[1:0])
         2'b00:   w_byte = mem_RD[7:0];
         2'b01:   w_byte = mem_RD[15:8];
         2'b10:   w_byte = mem_RD[23:16];
         default: w_byte = mem_RD[31:24];
      endcase
   end

   assign w_half = r_addr[1] ? mem_RD[31:16] : mem_RD[15:0];

   always_comb begin
      w_load_data = mem_RD;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {24'h0, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_data = {16'h0, w_half};
         default: w_load_data = mem_RD;
      endcase
   end

   // Store merge: replace only the target lane of the read word
   always_comb begin
      w_merged = mem_RD;
      if (r_funct3[1:0] == 2'b00) begin
         case (r_addr[1:0])
            2'b00:   w_merged[7:0]   = r_mem_wd[7:0];
            2'b01:   w_merged[15:8]  = r_mem_wd[7:0];
            2'b10:   w_merged[23:16] = r_mem_wd[7:0];
            default: w_merged[31:24] = r_mem_wd[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merged[31:16] = r_mem_wd[15:0];
      end else begin
         w_merged[15:0] = r_mem_wd[15:0];
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (req_valid) begin
               if (w_err_req) begin
                  w_state_next = StResp;
               end else if (req_store && (req_funct3 == 3'b010)) begin
                  w_state_next = StWrite;
               end else begin
                  w_state_next = StRead;
               end
            end
         end
         StRead:  w_state_next = r_store ? StWrite : StResp;
         StWrite: w_state_next = StResp;
         StResp:  if (rsp_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= StIdle;
         r_addr   <= '0;
         r_funct3 <= 3'b000;
         r_store  <= 1'b0;
         r_mem_wd <= 32'h0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_addr   <= w_addr_aligned;
            r_funct3 <= req_funct3;
            r_store  <= req_store;
            r_mem_wd <= req_wdata;
            r_rdata  <= 32'h0;
            r_err    <= w_err_req;
         end
         if (r_state == StRead) begin
            if (r_store) begin
               r_mem_wd <= w_merged;
            end else begin
               r_rdata <= w_load_data;
            end
         end
      end
   end

   // Write enable is decoded from state so an asynchronous reset drops it at once
   assign mem_MemWrite = (r_state == StWrite);
   assign mem_A        = {r_addr[ADDR_W-1:2], 2'b00};
   assign mem_WD       = r_mem_wd;
   assign req_ready    = (r_state == StIdle) && !reset;
   assign rsp_valid    = (r_state == StResp);
   assign rsp_rdata    = r_rdata;
   assign rsp_err      = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit with a behavioural word memory. Stimulus pushes
// the expected response into a queue; a monitor pops and compares on every
// response handshake.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_MemWrite;
   logic [31:0] mem_RD;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests;
   int          n_fail;
   int          wr_cnt;
   logic [31:0] mem [0:63];

   load_store_unit #(
      .ADDR_W          (32),
      .ERR_ON_MISALIGN (1'b1)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_store    (req_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_A        (mem_A),
      .mem_WD       (mem_WD),
      .mem_MemWrite (mem_MemWrite),
      .mem_RD       (mem_RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: combinational read, write on rising edge
   assign mem_RD = mem[mem_A[7:2]];
   always @(posedge clk) begin
      if (mem_MemWrite) mem[mem_A[7:2]] = mem_WD;
   end

   always @(negedge clk) begin
      if (mem_MemWrite) wr_cnt = wr_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL unexpected_rsp: got rdata %h err %b, expected none", rsp_rdata, rsp_err);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
         end
      end
   end

   // Waits for ready, presents the request and returns #1 after the accept edge
   task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input logic push);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      if (push) sb_q.push_back('{rdata: exp_rd, err: exp_err});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Latency in cycles, accept edge being the end of cycle 0
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_txn(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_wr);
      int w0;
      int lat;
      w0 = wr_cnt;
      send(st, f3, a, wd, exp_rd, exp_err, 1'b1);
      wait_rsp(lat);
      chk({name, "_latency"}, lat, exp_lat);
      @(posedge clk);
      #1;
      chk({name, "_writes"}, wr_cnt - w0, exp_wr);
   endtask

   initial begin
      int lat;
      n_tests    = 0;
      n_fail     = 0;
      wr_cnt     = 0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h80FF7F01;
      mem[8] = 32'h11223344;

      #1;
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_memwrite", {31'h0, mem_MemWrite}, 32'h0);
      chk("rst_mem_A", mem_A, 32'h0);
      chk("rst_mem_WD", mem_WD, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

      // Word store then load
      do_txn("sw0", 1'b1, 3'b010, 32'h0, 32'hABCDEF12, 32'h0, 1'b0, 2, 1);
      chk("sw0_mem", mem[0], 32'hABCDEF12);
      do_txn("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'hABCDEF12, 1'b0, 2, 0);

      // Sub-word loads from 0x80FF7F01
      do_txn("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 1'b0, 2, 0);
      do_txn("lb12", 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0);
      do_txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 0);
      do_txn("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0);
      do_txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080FF, 1'b0, 2, 0);
      do_txn("lh10", 1'b0, 3'b001, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2, 0);

      // Read-modify-write stores
      do_txn("sb21", 1'b1, 3'b000, 32'h21, 32'h123456AA, 32'h0, 1'b0, 3, 1);
      chk("sb21_mem", mem[8], 32'h1122AA44);
      do_txn("sh22", 1'b1, 3'b001, 32'h22, 32'h9999BEEF, 32'h0, 1'b0, 3, 1);
      chk("sh22_mem", mem[8], 32'hBEEFAA44);

      // Errors: no memory write, response in cycle 1
      do_txn("lw6_err", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
      do_txn("sh3_err", 1'b1, 3'b001, 32'h3, 32'hFFFF, 32'h0, 1'b1, 1, 0);
      do_txn("sbu_err", 1'b1, 3'b100, 32'h0, 32'h55, 32'h0, 1'b1, 1, 0);
      do_txn("f3_111_err", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
      chk("err_mem0_kept", mem[0], 32'hABCDEF12);

      // Back-pressure: response held while rsp_ready is low
      rsp_ready = 1'b0;
      send(1'b0, 3'b010, 32'h0, 32'h0, 32'hABCDEF12, 1'b0, 1'b1);
      wait_rsp(lat);
      chk("hold_latency", lat, 2);
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      sb_q.push_back('{rdata: 32'h80FF7F01, err: 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
         chk("hold_rsp_rdata", rsp_rdata, 32'hABCDEF12);
         chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("post_hs_req_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("second_latency", lat, 2);
      @(posedge clk);
      #1;

      // Reset during WRITE of a sub-word store
      send(1'b1, 3'b000, 32'h21, 32'h55, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_wr_active", {31'h0, mem_MemWrite}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_wr_dropped", {31'h0, mem_MemWrite}, 32'h0);
      chk("rst_wr_no_rsp", {31'h0, rsp_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_wr_mem_kept", mem[8], 32'hBEEFAA44);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_wr_still_no_rsp", {31'h0, rsp_valid}, 32'h0);

      chk("sb_empty", sb_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the single-ported word data memory (clk, A, WD, MemWrite, RD; combinational read, write at posedge clk when MemWrite=1).
- Accepts load/store requests from the core with RISC-V funct3 width encoding and performs byte and halfword access on top of the word-only memory.
- Loads use extract plus sign/zero extension. Sub-word stores use a read-modify-write sequence.
- Sits between the execute stage and data_memory.

Parameters:
- ADDR_W, 32, width of the request address and mem_A.
- ERR_ON_MISALIGN, 1: 1 = misaligned halfword/word access returns an error with no memory access; 0 = low address bits are forced to alignment and the access proceeds.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned access or illegal funct3.
- mem_A  output  ADDR_W  word address to memory, {addr[ADDR_W-1:2],2'b00}.
- mem_WD  output  32  write data to memory.
- mem_MemWrite  output  1  memory write enable.
- mem_RD  input  32  memory read data, combinational from mem_A.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_MemWrite=0, mem_A=0, mem_WD=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 once reset is deasserted.
  - Reset during WRITE drops mem_MemWrite before the next edge, so no write occurs. Any in-flight request is discarded with no response.
- Handshake:
  - A request is accepted on the edge where req_valid and req_ready are both 1. addr, funct3, store and wdata are registered at that edge.
  - The response completes on the edge where rsp_valid and rsp_ready are both 1, then the unit returns to IDLE.
  - req_ready is 0 from acceptance until the unit is back in IDLE, so at most one request is outstanding.
- States: IDLE, READ, WRITE, RESP.
  - IDLE: req_ready=1. On accept, the next state is chosen in this priority order:
    - illegal funct3 (011, 110, 111; 100 or 101 with store) -> RESP with err.
    - misaligned (H with addr[0]=1, W with addr[1:0]!=0) and ERR_ON_MISALIGN=1 -> RESP with err.
    - store word -> WRITE.
    - otherwise -> READ.
  - READ: drive mem_A; mem_MemWrite=0.
    - Load: rsp_rdata is registered at the end of the cycle, next state RESP.
    - Sub-word store: the merged word is registered into mem_WD, next state WRITE.
  - WRITE: mem_A held, mem_MemWrite=1 for exactly one cycle, next state RESP.
  - RESP: rsp_valid=1, held stable until rsp_ready. mem_MemWrite=0.
- Latency (accept edge = cycle 0):
  - load: rsp_valid in cycle 2.
  - SW: write at edge ending cycle 1, rsp_valid in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, rsp_valid in cycle 3.
  - error: rsp_valid in cycle 1, with no mem_MemWrite.
- Load extract uses off = addr[1:0]:
  - B: byte mem_RD[8*off+7:8*off], sign-extended (000) or zero-extended (100).
  - H: mem_RD[16*addr[1]+15 : 16*addr[1]], sign- or zero-extended.
  - W: mem_RD unchanged.
- Store merge: the target byte or half lane of the read word is replaced by wdata[7:0] or wdata[15:0]. All other lanes keep the read value. SW writes wdata directly.
- Little-endian byte order.
- mem_A is held constant from READ through WRITE, so the merge and the write target the same word.

Test Plan:
- SW addr 0x0 wdata 0xABCDEF12, then LW addr 0x0 -> mem_MemWrite high for exactly 1 cycle; rsp_rdata=0xABCDEF12, err=0.
- Memory word @0x10 = 0x80FF7F01: LB 0x11=0x0000007F, LB 0x12=0xFFFFFFFF, LBU 0x13=0x00000080, LH 0x12=0xFFFF80FF, LHU 0x12=0x000080FF.
- Word @0x20=0x11223344: SB 0x21 wdata 0xAA -> word=0x1122AA44. Then SH 0x22 wdata 0xBEEF -> word=0xBEEFAA44. Check 3-cycle store latency.
- LW 0x6, SH 0x3, and store with funct3=100 -> rsp_err=1 in cycle 1, rsp_rdata=0, mem_MemWrite never asserted.
- Hold rsp_ready=0 for 5 cycles after a LW -> rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until the response handshake.
- Assert reset during the WRITE cycle of SB 0x21 -> mem_MemWrite falls immediately, the memory word is unchanged, no rsp_valid appears, and req_ready=1 after reset is released.
